// File: rtl/uart_tx_serializer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx_serializer
// Serialises one parallel word into an asynchronous UART frame:
//   start (0), DATA_BITS data bits LSB first, optional parity, STOP_BITS stops.
// Bit timing comes entirely from baud_tick; every state boundary sits on a
// clk edge where baud_tick = 1.
//
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit between
// the data bits and the stop bits (even parity when PARITY_ODD = 0, odd when 1).
// Without the macro no parity logic is built and PARITY_ODD is ignored.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   baud_tick  in   one-clk pulse per bit time
//   tx_data    in   [DATA_BITS-1:0] word to send
//   tx_valid   in   tx_data is valid
//   tx_ready   out  block can accept a word (IDLE only)
//   tx         out  serial line, idle high, registered
//   tx_busy    out  frame in progress (any state but IDLE)
//   tx_done    out  one-clk pulse as the frame completes
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DATA_BITS);
  localparam logic [1:0]    STOP_ONE  = 2'd1;
  localparam logic [1:0]    STOP_LAST = 2'(STOP_BITS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd5
  } state_t;

  state_t               state_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [CW-1:0]        bit_cnt_r;
  logic [1:0]           stop_cnt_r;
  logic                 tx_r;
  logic                 ready_r;
  logic                 busy_r;
  logic                 done_r;

`ifdef UART_TX_PARITY_EN
  logic                 par_r;

  // Parity over the latched word; odd sense inverts the even result.
  function automatic logic parity_f(input logic [DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction
`else
  // PARITY_ODD only matters when parity is compiled in.
  logic unused_parity_odd_s;
  assign unused_parity_odd_s = (PARITY_ODD != 0);
`endif

  assign tx       = tx_r;
  assign tx_ready = ready_r;
  assign tx_busy  = busy_r;
  assign tx_done  = done_r;

  // Frame sequencer: state, shift register, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      shift_r    <= '0;
      bit_cnt_r  <= '0;
      stop_cnt_r <= 2'd0;
      tx_r       <= 1'b1;
      ready_r    <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_r      <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          // baud_tick is ignored here; only an accepted word leaves IDLE.
          if (tx_valid && ready_r) begin
            shift_r <= tx_data;
`ifdef UART_TX_PARITY_EN
            par_r   <= parity_f(tx_data, 1'(PARITY_ODD));
`endif
            state_r <= S_WAIT;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        S_WAIT: begin
          // Align the start bit to a tick so it lasts a full bit time.
          if (baud_tick) begin
            state_r <= S_START;
            tx_r    <= 1'b0;
          end
        end
        S_START: begin
          if (baud_tick) begin
            state_r   <= S_DATA;
            tx_r      <= shift_r[0];
            shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
            bit_cnt_r <= CNT_ONE;
          end
        end
        S_DATA: begin
          // bit_cnt_r counts bits already placed on the line.
          if (baud_tick) begin
            if (bit_cnt_r == CNT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_r    <= S_PARITY;
              tx_r       <= par_r;
`else
              state_r    <= S_STOP;
              tx_r       <= 1'b1;
              stop_cnt_r <= STOP_ONE;
`endif
            end else begin
              tx_r      <= shift_r[0];
              shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
              bit_cnt_r <= bit_cnt_r + CNT_ONE;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_tick) begin
            state_r    <= S_STOP;
            tx_r       <= 1'b1;
            stop_cnt_r <= STOP_ONE;
          end
        end
`endif
        S_STOP: begin
          if (baud_tick) begin
            if (stop_cnt_r == STOP_LAST) begin
              state_r    <= S_IDLE;
              done_r     <= 1'b1;
              ready_r    <= 1'b1;
              busy_r     <= 1'b0;
              bit_cnt_r  <= '0;
              stop_cnt_r <= 2'd0;
            end else begin
              stop_cnt_r <= stop_cnt_r + STOP_ONE;
            end
          end
        end
        default: begin
          state_r    <= S_IDLE;
          tx_r       <= 1'b1;
          ready_r    <= 1'b1;
          busy_r     <= 1'b0;
          bit_cnt_r  <= '0;
          stop_cnt_r <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (legal 5..8).
REQ-002 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal 1 or 2).
REQ-003 The block SHALL have parameter PARITY_ODD, default 0, meaning parity sense (0 even, 1 odd), used only when parity is compiled in.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 baud_tick  input  1  one-clk pulse per bit time, from the TX baud rate generator.
REQ-007 tx_data  input  DATA_BITS  parallel byte to send.
REQ-008 tx_valid  input  1  tx_data is valid.
REQ-009 tx_ready  output  1  block can accept a byte.
REQ-010 tx  output  1  serial line; idle high; registered.
REQ-011 tx_busy  output  1  frame in progress.
REQ-012 tx_done  output  1  one-clk pulse when a frame completes.

Function
REQ-013 The block SHALL implement states IDLE, WAIT, START, DATA, PARITY (parity build only) and STOP.
REQ-014 The block SHALL assert tx_ready only in IDLE; a byte is accepted on the clk edge where tx_valid and tx_ready are both 1.
REQ-015 On accept, the block SHALL latch tx_data into a shift register, enter WAIT and keep tx=1; later tx_data changes SHALL NOT affect the frame.
REQ-016 In WAIT, on baud_tick, the block SHALL enter START and drive tx=0 from the next clk; the start bit SHALL NOT begin before this tick.
REQ-017 START, DATA, PARITY and STOP SHALL each last exactly one baud_tick interval, and a state SHALL advance only on the clk edge where baud_tick=1.
REQ-018 DATA SHALL send DATA_BITS bits LSB first, with a bit counter of width clog2(DATA_BITS+1), and SHALL leave after bit DATA_BITS-1.
REQ-019 STOP SHALL drive tx=1 for STOP_BITS tick intervals, then return to IDLE.
REQ-020 On the STOP to IDLE transition, the block SHALL pulse tx_done high for exactly 1 clk, and tx_ready SHALL be 1 from the following clk.
REQ-021 tx_busy SHALL be 1 in every state except IDLE.
REQ-022 baud_tick in IDLE SHALL be ignored.
REQ-023 tx_valid while tx_ready=0 SHALL be ignored and SHALL NOT be queued.
REQ-024 A byte accepted right after tx_done SHALL start one full bit time after the previous stop bit ends, because of the WAIT alignment; this minimum inter-frame gap is the required behaviour.

Reset
REQ-025 While rst_n=0 the block SHALL be in IDLE with tx=1, tx_ready=1, tx_busy=0, tx_done=0, and the shift register and counters cleared; this takes effect immediately, including mid-frame.
REQ-026 After rst_n rises, the block SHALL accept a byte on the first clk edge where tx_valid=1.

Configuration
REQ-027 With macro UART_TX_PARITY_EN defined, the block SHALL insert a PARITY state between DATA and STOP that sends the XOR of the latched data bits XOR PARITY_ODD.
REQ-028 Without UART_TX_PARITY_EN, DATA SHALL go directly to STOP, no parity logic SHALL be built, and PARITY_ODD SHALL have no effect.

Verification (bench baud_tick every 16 clk unless stated)
REQ-029 Send 0x55, no parity -> after the WAIT tick, tx = 0,1,0,1,0,1,0,1,0,1, each held 16 clk; tx_done pulses once; tx_busy high for the whole frame.
REQ-030 Parity build, PARITY_ODD=0, send 0x80 -> tx = 0, 0,0,0,0,0,0,0,1, parity 1, stop 1; repeat with PARITY_ODD=1 -> parity 0.
REQ-031 Accept 0xFF, then hold tx_valid=1 with tx_data=0x00 for the whole frame -> tx_ready=0 throughout, the frame carries 0xFF, and 0x00 is accepted only after tx_done.
REQ-032 Assert rst_n=0 during data bit 3 of 0xA5 -> tx=1 with no clk edge, tx_busy=0; after release, send 0x3C -> a complete, correct frame.
REQ-033 STOP_BITS=2, send 0x00 -> tx low for 9 bit times, then high for 2 bit times before tx_done.
REQ-034 Send 0x12 and, on the clk after the accept, change tx_data to 0xFF -> the frame carries 0x12.
